// File: rtl/ef_pwmcap_pkg.sv
// ef_pwmcap_pkg: shared FSM encoding and default sizes for the PWM capture block.
package ef_pwmcap_pkg;
    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;
    localparam int CW_DEF      = 32;
    localparam int PW_DEF      = 16;
    localparam int FLT_LEN_DEF = 3;
endpackage

// File: rtl/ef_pwmcap_if.sv
// ef_pwmcap_if: control inputs and measurement results of ef_pwm_capture.
interface ef_pwmcap_if
    import ef_pwmcap_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int PW = PW_DEF
);
    logic          en;
    logic [PW-1:0] pr;
    logic          pol;
    logic          clr;
    logic          pwm_in;
    logic [CW-1:0] high_time;
    logic [CW-1:0] period;
    logic          cap_done;
    logic          ovf;
    logic          irq;
    modport master (output en, pr, pol, clr, pwm_in, input high_time, period, cap_done, ovf, irq);
    modport slave  (input en, pr, pol, clr, pwm_in, output high_time, period, cap_done, ovf, irq);
endinterface

// File: rtl/ef_pwmcap_sync.sv
// ef_pwmcap_sync: 2-FF synchronizer, optional glitch filter (EF_PWMCAP_FILTER_EN), polarity and edge detect.
module ef_pwmcap_sync
    import ef_pwmcap_pkg::*;
#(
    parameter int FLT_LEN = FLT_LEN_DEF
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic pwm_in,
    input  logic pol,
    output logic rise,
    output logic fall
);
`ifdef EF_PWMCAP_FILTER_EN
    localparam int FL = FLT_LEN;
`else
    localparam int FL = 0 * FLT_LEN;
`endif
    logic s1, s2, flt, lvl, prev;
    assign lvl = flt ^ pol;
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= pwm_in;
            s2   <= s1;
            prev <= lvl;
            rise <= lvl & ~prev;
            fall <= ~lvl & prev;
        end
    end
    if (FL > 0) begin : g_flt
        localparam int RW = $clog2(FL + 1);
        logic [RW-1:0] run;
        // a new level is accepted only after FL consecutive differing samples
        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn) begin
                run <= '0;
                flt <= 1'b0;
            end else if (s2 == flt) begin
                run <= '0;
            end else if (run == RW'(FL - 1)) begin
                run <= '0;
                flt <= s2;
            end else begin
                run <= run + RW'(1);
            end
        end
    end else begin : g_nof
        assign flt = s2;
    end
endmodule

// File: rtl/ef_pwm_capture.sv
// ef_pwm_capture: measures PWM period and high time in prescaled ticks.
// Optional glitch filter on the input path is enabled by defining EF_PWMCAP_FILTER_EN.
module ef_pwm_capture
    import ef_pwmcap_pkg::*;
#(
    parameter int CW      = CW_DEF,
    parameter int PW      = PW_DEF,
    parameter int FLT_LEN = FLT_LEN_DEF
) (
    input logic        PCLK,
    input logic        PRESETn,
    ef_pwmcap_if.slave bus
);
    localparam logic [CW-1:0] C1 = 1;
    localparam logic [PW-1:0] P1 = 1;
    logic rise, fall;
    ef_pwmcap_sync #(.FLT_LEN(FLT_LEN)) u_sync (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .pwm_in (bus.pwm_in),
        .pol    (bus.pol),
        .rise   (rise),
        .fall   (fall)
    );
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, hold, high_time, period;
    logic [PW-1:0] psc, prs;
    logic          tick, sat, cap, ovf_set, restart, zero, cap_done, ovf;
    assign tick = psc == prs;
    assign sat  = &cnt;
    always_comb begin
        state_nxt = state;
        cap       = 1'b0;
        ovf_set   = 1'b0;
        case (state)
            IDLE: state_nxt = ARM;
            ARM:  state_nxt = rise ? HIGH : ARM;
            HIGH: begin
                ovf_set   = tick & sat;
                state_nxt = ovf_set ? ARM : fall ? LOW : HIGH;
            end
            LOW: begin
                cap       = rise;
                ovf_set   = tick & sat & ~rise;
                state_nxt = rise ? HIGH : ovf_set ? ARM : LOW;
            end
            default: state_nxt = IDLE;
        endcase
        if (!bus.en) begin
            state_nxt = IDLE;
            cap       = 1'b0;
            ovf_set   = 1'b0;
        end
    end
    assign restart = rise && (state == ARM || state == LOW) && state_nxt == HIGH;
    assign zero    = state_nxt == IDLE || state_nxt == ARM;
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_nxt;
    end
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt       <= '0;
            psc       <= '0;
            prs       <= '0;
            hold      <= '0;
            high_time <= '0;
            period    <= '0;
            cap_done  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            cap_done <= cap;
            ovf      <= ovf_set | (ovf & ~bus.clr);
            if (cap) begin
                period    <= cnt;
                high_time <= hold;
            end
            if (state == HIGH && fall) hold <= cnt;
            // the edge cycle is the first cycle of the new period; any tick there is dropped
            if (zero) begin
                cnt <= '0;
                psc <= '0;
            end else if (restart) begin
                prs <= bus.pr;
                cnt <= (bus.pr == '0) ? C1 : '0;
                psc <= (bus.pr == '0) ? '0 : P1;
            end else if (tick) begin
                cnt <= cnt + C1;
                psc <= '0;
            end else begin
                psc <= psc + P1;
            end
        end
    end
    assign bus.high_time = high_time;
    assign bus.period    = period;
    assign bus.cap_done  = cap_done;
    assign bus.ovf       = ovf;
    assign bus.irq       = cap_done | ovf;
endmodule

// File: tb/tb_ef_pwm_capture.sv
// tb_ef_pwm_capture: table-driven waveforms plus corner sequences; captures checked against an expectation queue.
module tb_ef_pwm_capture;
    import ef_pwmcap_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    ef_pwmcap_if #(.CW(32), .PW(16)) b ();
    ef_pwmcap_if #(.CW(8), .PW(16)) b8 ();
    ef_pwm_capture dut (.PCLK(clk), .PRESETn(rst_n), .bus(b.slave));
    ef_pwm_capture #(.CW(8)) dut8 (.PCLK(clk), .PRESETn(rst_n), .bus(b8.slave));
    typedef struct {
        int pr;
        bit pol;
        int hi;
        int lo;
        int exp_hi;
        int exp_per;
    } vec_t;
    typedef struct {
        longint hi;
        longint per;
    } exp_t;
    vec_t tbl[5];
    exp_t q[$];
    exp_t q8[$];
    exp_t e, e8;
    int nvec = 0;
    int nerr = 0;
    task automatic chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic pw(input logic v, input int n);
        b.pwm_in  = v;
        b8.pwm_in = v;
        idle(n);
    endtask
    always @(negedge clk) begin
        if (rst_n && b.cap_done) begin
            if (q.size() == 0) chk("unexpected_cap_done", b.cap_done, 0);
            else begin
                e = q.pop_front();
                chk("high_time", b.high_time, e.hi);
                chk("period", b.period, e.per);
                chk("irq", b.irq, 1);
            end
        end
        if (rst_n && b8.cap_done) begin
            if (q8.size() == 0) chk("unexpected_cap_done8", b8.cap_done, 0);
            else begin
                e8 = q8.pop_front();
                chk("high_time8", b8.high_time, e8.hi);
                chk("period8", b8.period, e8.per);
            end
        end
    end
    initial begin
        tbl[0] = '{0, 1'b0, 30, 70, 30, 100};
        tbl[1] = '{4, 1'b0, 30, 70, 6, 20};
        tbl[2] = '{0, 1'b1, 30, 70, 70, 100};
        tbl[3] = '{2, 1'b0, 10, 20, 3, 10};
        tbl[4] = '{0, 1'b0, 5, 5, 5, 10};
        b.en = 0; b.pr = 0; b.pol = 0; b.clr = 0; b.pwm_in = 0;
        b8.en = 0; b8.pr = 0; b8.pol = 0; b8.clr = 0; b8.pwm_in = 0;
        idle(3);
        chk("rst_high_time", b.high_time, 0);
        chk("rst_period", b.period, 0);
        chk("rst_cap_done", b.cap_done, 0);
        chk("rst_ovf", b.ovf, 0);
        chk("rst_irq", b.irq, 0);
        chk("rst_state", dut.state, IDLE);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b.en = 0;
            b.pr = 16'(tbl[i].pr);
            b.pol = tbl[i].pol;
            idle(5);
            b.en = 1;
            idle(5);
            for (int p = 0; p < 3; p++) begin
                if (p > 0) q.push_back('{longint'(tbl[i].exp_hi), longint'(tbl[i].exp_per)});
                pw(1'b1, tbl[i].hi);
                pw(1'b0, tbl[i].lo);
            end
            idle(20);
            chk("caps_seen", q.size(), 0);
        end
        // pr changed mid-period takes effect from the next period
        b.en = 0; b.pr = 0; b.pol = 0;
        idle(5);
        b.en = 1;
        idle(5);
        q.push_back('{30, 100});
        q.push_back('{15, 50});
        pw(1'b1, 10);
        b.pr = 1;
        pw(1'b1, 20); pw(1'b0, 70);
        pw(1'b1, 30); pw(1'b0, 70);
        pw(1'b1, 5); pw(1'b0, 5);
        idle(20);
        chk("pr_change_caps", q.size(), 0);
        // glitch in the low phase
        b.en = 0; b.pr = 0;
        idle(5);
        b.en = 1;
        idle(5);
`ifdef EF_PWMCAP_FILTER_EN
        q.push_back('{30, 100});
`else
        q.push_back('{30, 65});
        q.push_back('{2, 35});
`endif
        pw(1'b1, 30); pw(1'b0, 35); pw(1'b1, 2); pw(1'b0, 33);
        pw(1'b1, 30); pw(1'b0, 70);
        idle(20);
        chk("glitch_caps", q.size(), 0);
        // overflow on the 8-bit instance, then clear and a normal period
        b.en = 0;
        b8.en = 1;
        idle(5);
        pw(1'b1, 30); pw(1'b0, 270);
        chk("ovf8", b8.ovf, 1);
        chk("irq8_ovf", b8.irq, 1);
        chk("state8_arm", dut8.state, ARM);
        b8.clr = 1;
        idle(1);
        b8.clr = 0;
        chk("ovf8_clr", b8.ovf, 0);
        chk("irq8_clr", b8.irq, 0);
        pw(1'b1, 30); pw(1'b0, 70);
        q8.push_back('{30, 100});
        pw(1'b1, 30); pw(1'b0, 70);
        idle(10);
        chk("ovf8_after", b8.ovf, 0);
        chk("caps8_seen", q8.size(), 0);
        b8.en = 0;
        // en dropped mid-HIGH: outputs hold, no strobe
        b.en = 1;
        idle(5);
        pw(1'b1, 20); pw(1'b0, 60);
        q.push_back('{20, 80});
        pw(1'b1, 10);
        b.en = 0;
        pw(1'b1, 10); pw(1'b0, 60);
        pw(1'b1, 20); pw(1'b0, 60);
        idle(10);
        chk("hold_high_time", b.high_time, 20);
        chk("hold_period", b.period, 80);
        chk("en_drop_state", dut.state, IDLE);
        chk("en_drop_caps", q.size(), 0);
        // reset mid-LOW
        b.en = 1;
        idle(5);
        pw(1'b1, 20); pw(1'b0, 60);
        q.push_back('{20, 80});
        pw(1'b1, 20); pw(1'b0, 30);
        chk("pre_rst_period", b.period, 80);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_high_time", b.high_time, 0);
        chk("rst_mid_period", b.period, 0);
        chk("rst_mid_cap_done", b.cap_done, 0);
        chk("rst_mid_irq", b.irq, 0);
        chk("rst_mid_state", dut.state, IDLE);
        idle(2);
        rst_n = 1'b1;
        idle(10);
        chk("final_queue", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
